// File: rtl/imem_access_arbiter_pkg.sv
// Shared constants for the instruction-memory port arbiter and the InstructionMemory instance.
// Memory geometry defaults, the NOP encoding and the fetch anti-starvation limit.
package imem_access_arbiter_pkg;

  localparam int IMEM_SIZE       = 32;
  localparam int IMEM_MEM_SIZE   = 32;
  localparam int IMEM_STARVE_MAX = 4;

  localparam logic [31:0] NOP_WORD = 32'b0;

  // Width of a counter that must hold 0..max_val inclusive.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/imem_access_arbiter_if.sv
// Requester and memory-side signals of the instruction-memory arbiter.
// slave = arbiter view, master = fetch unit / loader / memory view.
interface imem_access_arbiter_if
  import imem_access_arbiter_pkg::*;
#(
  parameter int SIZE = IMEM_SIZE
) ();

  logic            fetch_req;
  logic [SIZE-1:0] fetch_addr;
  logic            fetch_gnt;
  logic            fetch_valid;
  logic [SIZE-1:0] fetch_data;

  logic            ld_req;
  logic [SIZE-1:0] ld_addr;
  logic [SIZE-1:0] ld_data;
  logic            ld_gnt;
  logic            ld_err;

  logic            mem_wea;
  logic [SIZE-1:0] mem_addra;
  logic [SIZE-1:0] mem_dina;
  logic [SIZE-1:0] mem_douta;

  modport slave (
    input  fetch_req, fetch_addr, ld_req, ld_addr, ld_data, mem_douta,
    output fetch_gnt, fetch_valid, fetch_data, ld_gnt, ld_err,
           mem_wea, mem_addra, mem_dina
  );

  modport master (
    output fetch_req, fetch_addr, ld_req, ld_addr, ld_data, mem_douta,
    input  fetch_gnt, fetch_valid, fetch_data, ld_gnt, ld_err,
           mem_wea, mem_addra, mem_dina
  );

endinterface

// File: rtl/imem_rr_starve_ctr.sv
// Loader-priority grant logic with a saturating fetch starvation counter.
// Grants are combinational; fetch is forced through once STARVE_MAX denials accumulate.
module imem_rr_starve_ctr
  import imem_access_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = IMEM_STARVE_MAX,
  parameter int CNT_W      = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_fetch_req,
  input  logic i_ld_req,
  output logic o_fetch_gnt,
  output logic o_ld_gnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] r_cnt;
  logic             w_fetch_denied;

  assign o_ld_gnt       = i_ld_req && (!i_fetch_req || (r_cnt < CNT_MAX));
  assign o_fetch_gnt    = i_fetch_req && !o_ld_gnt;
  assign w_fetch_denied = i_fetch_req && !o_fetch_gnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_fetch_denied) begin
      if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
    end else begin
      r_cnt <= '0;
    end
  end

endmodule

// File: rtl/imem_access_arbiter.sv
// Shares the single instruction-memory port between CPU fetch (reads) and the loader (writes).
// Registered issue and return stages give a fixed 2-cycle fetch latency.
module imem_access_arbiter
  import imem_access_arbiter_pkg::*;
#(
  parameter int SIZE       = IMEM_SIZE,
  parameter int MEM_SIZE   = IMEM_MEM_SIZE,
  parameter int STARVE_MAX = IMEM_STARVE_MAX
) (
  input  logic                  clka,
  input  logic                  rst_n,
  imem_access_arbiter_if.slave  bus
);

  localparam int              CNT_W   = cnt_width(STARVE_MAX);
  localparam logic [SIZE-1:0] DEPTH   = SIZE'(MEM_SIZE);
  localparam logic [SIZE-1:0] NOP_VAL = SIZE'(NOP_WORD);

  logic            w_fetch_gnt;
  logic            w_ld_gnt;
  logic            w_ld_oor;
  logic            w_fetch_oor;

  logic            r_wea;
  logic [SIZE-1:0] r_addra;
  logic [SIZE-1:0] r_dina;
  logic            r_ld_err;
  logic            r_rd_pend;
  logic            r_rd_oor;
  logic            r_fetch_valid;
  logic [SIZE-1:0] r_fetch_data;

  imem_rr_starve_ctr #(
    .STARVE_MAX (STARVE_MAX),
    .CNT_W      (CNT_W)
  ) u_ctr (
    .clk         (clka),
    .rst_n       (rst_n),
    .i_fetch_req (bus.fetch_req),
    .i_ld_req    (bus.ld_req),
    .o_fetch_gnt (w_fetch_gnt),
    .o_ld_gnt    (w_ld_gnt)
  );

  assign w_ld_oor    = (bus.ld_addr >= DEPTH);
  assign w_fetch_oor = (bus.fetch_addr >= DEPTH);

  // Issue stage: an out-of-range write is still granted but never reaches the array.
  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      r_wea     <= 1'b0;
      r_addra   <= '0;
      r_dina    <= '0;
      r_ld_err  <= 1'b0;
      r_rd_pend <= 1'b0;
      r_rd_oor  <= 1'b0;
    end else begin
      r_ld_err  <= w_ld_gnt && w_ld_oor;
      r_rd_pend <= w_fetch_gnt;
      r_rd_oor  <= w_fetch_gnt && w_fetch_oor;
      if (w_ld_gnt) begin
        r_addra <= bus.ld_addr;
        r_dina  <= bus.ld_data;
        r_wea   <= !w_ld_oor;
      end else if (w_fetch_gnt) begin
        r_addra <= bus.fetch_addr;
        r_wea   <= 1'b0;
      end else begin
        r_wea   <= 1'b0;
      end
    end
  end

  // Return stage: out-of-range fetches yield a NOP instead of whatever the array drives.
  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_valid <= 1'b0;
      r_fetch_data  <= '0;
    end else begin
      r_fetch_valid <= r_rd_pend;
      if (r_rd_pend) r_fetch_data <= r_rd_oor ? NOP_VAL : bus.mem_douta;
    end
  end

  assign bus.fetch_gnt   = w_fetch_gnt;
  assign bus.ld_gnt      = w_ld_gnt;
  assign bus.fetch_valid = r_fetch_valid;
  assign bus.fetch_data  = r_fetch_data;
  assign bus.ld_err      = r_ld_err;
  assign bus.mem_wea     = r_wea;
  assign bus.mem_addra   = r_addra;
  assign bus.mem_dina    = r_dina;

endmodule

// File: tb/tb_imem_access_arbiter.sv
// Bench for imem_access_arbiter: memory model behind the port, fetch scoreboard, directed scenarios.
module tb_imem_access_arbiter;
  import imem_access_arbiter_pkg::*;

  localparam int W     = 32;
  localparam int DEPTH = 32;

  logic clka;
  logic rst_n;

  imem_access_arbiter_if #(.SIZE(W)) u_if ();

  imem_access_arbiter #(.SIZE(W), .MEM_SIZE(DEPTH), .STARVE_MAX(4)) dut (
    .clka  (clka),
    .rst_n (rst_n),
    .bus   (u_if)
  );

  initial clka = 1'b0;
  always #5 clka = ~clka;

  // Memory behind the port: synchronous write, asynchronous read; out-of-range reads return junk.
  logic [W-1:0] mem     [DEPTH];
  logic [W-1:0] ref_mem [DEPTH];

  always @(posedge clka)
    if (u_if.mem_wea && (u_if.mem_addra < DEPTH)) mem[u_if.mem_addra[4:0]] <= u_if.mem_dina;

  assign u_if.mem_douta = (u_if.mem_addra < DEPTH) ? mem[u_if.mem_addra[4:0]] : 32'hBAD0_BAD0;

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h @%0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: expected fetch words are queued at grant and popped at fetch_valid.
  logic [W-1:0] exp_q [$];

  always @(negedge clka) begin
    if (!rst_n) begin
      exp_q.delete();
      chk("rst_fvalid", 32'(u_if.fetch_valid), 32'd0);
      chk("rst_fdata",  u_if.fetch_data, 32'd0);
      chk("rst_lderr",  32'(u_if.ld_err), 32'd0);
      chk("rst_wea",    32'(u_if.mem_wea), 32'd0);
      chk("rst_addra",  u_if.mem_addra, 32'd0);
      chk("rst_dina",   u_if.mem_dina, 32'd0);
    end else begin
      if (u_if.fetch_valid) begin
        if (exp_q.size() == 0) chk("sb_unexpected_valid", 32'd1, 32'd0);
        else                   chk("sb_fetch_data", u_if.fetch_data, exp_q.pop_front());
      end
      if (u_if.ld_gnt && (u_if.ld_addr < DEPTH)) ref_mem[u_if.ld_addr[4:0]] = u_if.ld_data;
      if (u_if.fetch_gnt)
        exp_q.push_back((u_if.fetch_addr < DEPTH) ? ref_mem[u_if.fetch_addr[4:0]] : 32'd0);
    end
  end

  task automatic step();
    @(posedge clka);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]     = 32'h1000_0000 + i;
      ref_mem[i] = 32'h1000_0000 + i;
    end
    mem[1]     = 32'h2443_0003;
    ref_mem[1] = 32'h2443_0003;

    rst_n           = 1'b0;
    u_if.fetch_req  = 1'b0;
    u_if.fetch_addr = '0;
    u_if.ld_req     = 1'b0;
    u_if.ld_addr    = '0;
    u_if.ld_data    = '0;
    repeat (3) @(negedge clka);
    chk("reset_gnt", 32'({u_if.fetch_gnt, u_if.ld_gnt}), 32'd0);
    step();
    rst_n = 1'b1;

    // Back-to-back fetches of word 1.
    u_if.fetch_req  = 1'b1;
    u_if.fetch_addr = 32'd1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clka);
      chk("b2b_gnt", 32'(u_if.fetch_gnt), 32'd1);
      chk("b2b_valid", 32'(u_if.fetch_valid), (c >= 2) ? 32'd1 : 32'd0);
      if (c >= 2) chk("b2b_data", u_if.fetch_data, 32'h2443_0003);
    end
    step();
    u_if.fetch_req = 1'b0;
    repeat (4) @(negedge clka);

    // Write word 5, then fetch it the very next cycle.
    step();
    u_if.ld_req  = 1'b1;
    u_if.ld_addr = 32'd5;
    u_if.ld_data = 32'hDEAD_BEEF;
    @(negedge clka);
    chk("wr_ld_gnt", 32'(u_if.ld_gnt), 32'd1);
    step();
    u_if.ld_req     = 1'b0;
    u_if.fetch_req  = 1'b1;
    u_if.fetch_addr = 32'd5;
    @(negedge clka);
    chk("wr_wea_hi", 32'(u_if.mem_wea), 32'd1);
    chk("wr_fetch_gnt", 32'(u_if.fetch_gnt), 32'd1);
    step();
    u_if.fetch_req = 1'b0;
    @(negedge clka);
    chk("wr_wea_lo", 32'(u_if.mem_wea), 32'd0);
    @(negedge clka);
    chk("wr_rd_valid", 32'(u_if.fetch_valid), 32'd1);
    chk("wr_rd_data", u_if.fetch_data, 32'hDEAD_BEEF);
    repeat (2) @(negedge clka);

    // Contention: 4 loads then 1 forced fetch, repeating.
    step();
    u_if.ld_req     = 1'b1;
    u_if.ld_addr    = 32'd10;
    u_if.ld_data    = 32'hA000_0000;
    u_if.fetch_req  = 1'b1;
    u_if.fetch_addr = 32'd2;
    for (int i = 0; i < 12; i++) begin
      @(negedge clka);
      chk("starve_ld_gnt", 32'(u_if.ld_gnt), ((i % 5) != 4) ? 32'd1 : 32'd0);
      chk("starve_f_gnt", 32'(u_if.fetch_gnt), ((i % 5) == 4) ? 32'd1 : 32'd0);
      chk("starve_cnt_le4", 32'(dut.u_ctr.r_cnt <= 3'd4), 32'd1);
      step();
      if ((i % 5) != 4) u_if.ld_data = u_if.ld_data + 32'd1;
    end
    u_if.ld_req    = 1'b0;
    u_if.fetch_req = 1'b0;
    repeat (4) @(negedge clka);

    // Out-of-range write.
    step();
    u_if.ld_req  = 1'b1;
    u_if.ld_addr = 32'd40;
    u_if.ld_data = 32'h5555_5555;
    @(negedge clka);
    chk("oor_ld_gnt", 32'(u_if.ld_gnt), 32'd1);
    chk("oor_err_pre", 32'(u_if.ld_err), 32'd0);
    step();
    u_if.ld_req = 1'b0;
    @(negedge clka);
    chk("oor_wea", 32'(u_if.mem_wea), 32'd0);
    chk("oor_err", 32'(u_if.ld_err), 32'd1);
    @(negedge clka);
    chk("oor_err_post", 32'(u_if.ld_err), 32'd0);
    chk("oor_wea_post", 32'(u_if.mem_wea), 32'd0);
    chk("oor_mem8", mem[8], 32'h1000_0008);

    // Out-of-range fetch returns a NOP.
    step();
    u_if.fetch_req  = 1'b1;
    u_if.fetch_addr = 32'd32;
    @(negedge clka);
    chk("oorf_gnt", 32'(u_if.fetch_gnt), 32'd1);
    step();
    u_if.fetch_req = 1'b0;
    @(negedge clka);
    chk("oorf_valid_n1", 32'(u_if.fetch_valid), 32'd0);
    @(negedge clka);
    chk("oorf_valid", 32'(u_if.fetch_valid), 32'd1);
    chk("oorf_data", u_if.fetch_data, 32'd0);
    repeat (2) @(negedge clka);

    // Reset right after a fetch grant drops the in-flight read.
    step();
    u_if.fetch_req  = 1'b1;
    u_if.fetch_addr = 32'd3;
    @(negedge clka);
    chk("rstf_gnt", 32'(u_if.fetch_gnt), 32'd1);
    step();
    u_if.fetch_req = 1'b0;
    rst_n          = 1'b0;
    repeat (3) @(negedge clka);
    step();
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clka);
      chk("rstf_no_valid", 32'(u_if.fetch_valid), 32'd0);
    end

    step();
    u_if.fetch_req  = 1'b1;
    u_if.fetch_addr = 32'd1;
    @(negedge clka);
    chk("resume_gnt", 32'(u_if.fetch_gnt), 32'd1);
    step();
    u_if.fetch_req = 1'b0;
    @(negedge clka);
    @(negedge clka);
    chk("resume_valid", 32'(u_if.fetch_valid), 32'd1);
    chk("resume_data", u_if.fetch_data, 32'h2443_0003);
    repeat (3) @(negedge clka);
    chk("sb_drain", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
